// File: rtl/fft_pkg.sv
// Shared constants, types and helper functions for the FFT output reorder block.
package fft_pkg;

    localparam int DEFAULT_N     = 128;
    localparam int DEFAULT_WIDTH = 16;
    localparam int MAX_LOG2N     = 12;

    typedef enum logic {
        IDLE,
        READ
    } rd_state_t;

    function automatic int log2_int(input int value);
        int result;
        result = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < value) result = b + 1;
        end
        return result;
    endfunction

    // Reverse the low 'bits' bits of value; bits above 'bits' come back as zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] value,
                                                    input int bits);
        logic [MAX_LOG2N-1:0] full_rev;
        for (int b = 0; b < MAX_LOG2N; b++) begin
            full_rev[b] = value[MAX_LOG2N-1-b];
        end
        return full_rev >> (MAX_LOG2N - bits);
    endfunction

endpackage

// File: rtl/fft_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Kept standalone so a vendor RAM macro can replace it.
module fft_dpram #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32
) (
    input  logic                 clock,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem [0:(1 << ADDR_BITS)-1];

    // NOTE: storage has no reset so it maps onto block RAM; readers never trust
    // a word before it has been written.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: takes bit-reversed FFT frames and re-emits them
// in natural bin order, one sample per clock.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idata_en,
    input  logic [WIDTH-1:0] idata_r,
    input  logic [WIDTH-1:0] idata_i,
    output logic             odata_en,
    output logic [WIDTH-1:0] odata_r,
    output logic [WIDTH-1:0] odata_i
);

    localparam int AW = log2_int(N);
    localparam int DW = 2 * WIDTH;

    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] rd_index;
    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    full;
    logic [1:0]    full_set;
    logic [1:0]    full_clr;
    logic          wr_last;
    logic          rd_active;
    logic          rd_last;
    logic          other_bank_ready;
    logic          primed;
    logic [DW-1:0] rd_data;
    rd_state_t     state;
    rd_state_t     state_next;

    assign wr_last   = idata_en && (wr_cnt == AW'(N - 1));
    assign rd_active = (state == READ);
    assign rd_last   = rd_active && (rd_cnt == AW'(N - 1));
    assign full_set  = {wr_last & wr_bank, wr_last & ~wr_bank};
    assign full_clr  = {rd_last & rd_bank, rd_last & ~rd_bank};
    assign rd_index  = AW'(bitrev(MAX_LOG2N'(rd_cnt), AW));

    // The bank about to be read may be completing on this very edge.
    assign other_bank_ready = rd_bank ? (full[0] | full_set[0]) : (full[1] | full_set[1]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (idata_en) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_last) wr_bank <= ~wr_bank;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) full <= '0;
        else       full <= (full | full_set) & ~full_clr;
    end

    // NOTE: every path assigns state_next because the default comes first,
    // so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (full[rd_bank]) state_next = READ;
            READ: if (rd_last && !other_bank_ready) state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            rd_bank  <= 1'b0;
            odata_en <= 1'b0;
            primed   <= 1'b0;
        end else begin
            state    <= state_next;
            rd_cnt   <= rd_active ? rd_cnt + 1'b1 : '0;
            odata_en <= rd_active;
            primed   <= primed | rd_active;
            if (rd_last) rd_bank <= ~rd_bank;
        end
    end

    fft_dpram #(
        .ADDR_BITS (AW + 1),
        .DATA_BITS (DW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (idata_en),
        .wr_addr ({wr_bank, wr_cnt}),
        .wr_data ({idata_r, idata_i}),
        .rd_en   (rd_active),
        .rd_addr ({rd_bank, rd_index}),
        .rd_data (rd_data)
    );

    // RAM output register is not reset; gate it to zero until a frame has been read.
    assign odata_r = primed ? rd_data[DW-1:WIDTH] : '0;
    assign odata_i = primed ? rd_data[WIDTH-1:0]  : '0;

endmodule
